// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// Package  : i2c_pkg
// Purpose  : Shared encodings and default timing constants for the I2C
//            master datapath (SCL timing generator, later the SDA path).
// Contents : speed-mode encodings, SCL phase state encoding, default
//            quarter-period divisors for a 50 MHz reference clock.
// Revision : 1.0 - initial release
// ============================================================================
package i2c_pkg;

  // Speed-mode select encodings (mode input of the SCL timing generator)
  localparam logic [1:0] MODE_STD    = 2'b00;
  localparam logic [1:0] MODE_FAST   = 2'b01;
  localparam logic [1:0] MODE_FPLUS  = 2'b10;
  localparam logic [1:0] MODE_CUSTOM = 2'b11;

  // SCL phase state machine: each SCL period is split into four quarters
  // (two low, two high) with IDLE between runs.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOW_A  = 3'd1,
    ST_LOW_B  = 3'd2,
    ST_HIGH_A = 3'd3,
    ST_HIGH_B = 3'd4
  } scl_state_t;

  // Default quarter-period lengths in 50 MHz reference cycles
  localparam int c_cnt_w     = 12;
  localparam int c_div_std   = 125;  // 100 kHz
  localparam int c_div_fast  = 31;   // ~400 kHz
  localparam int c_div_fplus = 12;   // ~1 MHz
  localparam int c_div_min   = 4;    // keeps 2-cycle sync latency inside HIGH_A

endpackage : i2c_pkg
`default_nettype wire

// File: rtl/i2c_sync2.sv
`default_nettype none
// ============================================================================
// Module   : i2c_sync2
// Purpose  : Two-flop synchroniser for an asynchronous pad level, with a
//            parametrised reset value so an idle-high bus line reads as
//            released while in reset.
// Ports    : clk      in  sampling clock (rising edge)
//            reset_n  in  synchronous active-low reset
//            d        in  asynchronous input level
//            q        out synchronised level, 2 cycles of latency
// Revision : 1.0 - initial release
// ============================================================================
module i2c_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule : i2c_sync2
`default_nettype wire

// File: rtl/i2c_scl_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : i2c_scl_timing_gen
// Purpose  : SCL timing generator for the I2C master. Drives the open-drain
//            SCL enable and emits quarter-period strobes for the bit engine.
//            Runtime speed select, slave clock stretching, and clean
//            start/stop of whole SCL periods under enable.
// Ports    : ref_clk     in  50 MHz reference, rising edge
//            reset_n     in  synchronous active-low reset
//            enable      in  run request (whole periods only)
//            mode        in  00 STD, 01 FAST, 10 FPLUS, 11 CUSTOM
//            custom_div  in  quarter-period used in CUSTOM mode
//            scl_in      in  raw SCL pad level (asynchronous)
//            scl_oe      out 1 = pull SCL low, 0 = release
//            low_mid     out strobe at mid-low (SDA change point)
//            high_mid    out strobe at mid-high (SDA sample point)
//            period_done out strobe at end of each SCL period
//            stretching  out slave is holding SCL low past release
//            idle        out generator is in IDLE
// Revision : 1.0 - initial release
// ============================================================================
module i2c_scl_timing_gen
  import i2c_pkg::*;
#(
  parameter int CNT_W     = c_cnt_w,
  parameter int DIV_STD   = c_div_std,
  parameter int DIV_FAST  = c_div_fast,
  parameter int DIV_FPLUS = c_div_fplus,
  parameter int DIV_MIN   = c_div_min
) (
  input  logic             ref_clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] custom_div,
  input  logic             scl_in,
  output logic             scl_oe,
  output logic             low_mid,
  output logic             high_mid,
  output logic             period_done,
  output logic             stretching,
  output logic             idle
);

  // --------------------------------------------------------------------------
  // SCL pad synchroniser; resets to 1 so the released bus reads high.
  // --------------------------------------------------------------------------
  logic w_scl_s;

  i2c_sync2 #(
    .RESET_VAL (1'b1)
  ) u_scl_sync (
    .clk     (ref_clk),
    .reset_n (reset_n),
    .d       (scl_in),
    .q       (w_scl_s)
  );

  // --------------------------------------------------------------------------
  // Divisor selection. Only sampled into r_div_q on entry to LOW_A, so mode
  // or custom_div changes never disturb a period already in progress.
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] w_div_sel;
  logic [CNT_W-1:0] w_div_eff;

  always_comb begin
    w_div_sel = CNT_W'(DIV_STD);
    case (mode)
      MODE_STD:    w_div_sel = CNT_W'(DIV_STD);
      MODE_FAST:   w_div_sel = CNT_W'(DIV_FAST);
      MODE_FPLUS:  w_div_sel = CNT_W'(DIV_FPLUS);
      MODE_CUSTOM: w_div_sel = custom_div;
      default:     w_div_sel = CNT_W'(DIV_STD);
    endcase
  end

  // Floor at DIV_MIN: a zero or tiny divisor would otherwise let the
  // synchroniser latency overrun HIGH_A and read the line before release.
  assign w_div_eff = (w_div_sel < CNT_W'(DIV_MIN)) ? CNT_W'(DIV_MIN) : w_div_sel;

  // --------------------------------------------------------------------------
  // Phase state machine with registered outputs
  // --------------------------------------------------------------------------
  scl_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_div_q;
  logic             r_scl_oe;
  logic             r_low_mid;
  logic             r_high_mid;
  logic             r_period_done;
  logic             r_stretching;
  logic             r_idle;
  logic             w_at_term;

  // r_div_q is never below DIV_MIN, so the subtraction cannot underflow
  assign w_at_term = (r_cnt == (r_div_q - CNT_W'(1)));

  always_ff @(posedge ref_clk) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_div_q       <= CNT_W'(DIV_MIN);
      r_scl_oe      <= 1'b0;
      r_low_mid     <= 1'b0;
      r_high_mid    <= 1'b0;
      r_period_done <= 1'b0;
      r_stretching  <= 1'b0;
      r_idle        <= 1'b1;
    end else begin
      // Strobes default low: each is a single-cycle pulse
      r_low_mid     <= 1'b0;
      r_high_mid    <= 1'b0;
      r_period_done <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          r_scl_oe <= 1'b0;
          r_cnt    <= '0;
          if (enable) begin
            r_state  <= ST_LOW_A;
            r_div_q  <= w_div_eff;
            r_scl_oe <= 1'b1;
            r_idle   <= 1'b0;
          end
        end

        ST_LOW_A: begin
          if (w_at_term) begin
            r_state   <= ST_LOW_B;
            r_cnt     <= '0;
            r_low_mid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        ST_LOW_B: begin
          if (w_at_term) begin
            r_state  <= ST_HIGH_A;
            r_cnt    <= '0;
            r_scl_oe <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        ST_HIGH_A: begin
          if (w_at_term) begin
            // Counter parks at terminal while a slave holds SCL low; the
            // high half only starts counting once the line is seen high.
            if (w_scl_s) begin
              r_state      <= ST_HIGH_B;
              r_cnt        <= '0;
              r_high_mid   <= 1'b1;
              r_stretching <= 1'b0;
            end else begin
              r_stretching <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        ST_HIGH_B: begin
          if (w_at_term) begin
            r_period_done <= 1'b1;
            r_cnt         <= '0;
            if (enable) begin
              r_state  <= ST_LOW_A;
              r_div_q  <= w_div_eff;
              r_scl_oe <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
              r_idle  <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        default: begin
          r_state      <= ST_IDLE;
          r_cnt        <= '0;
          r_scl_oe     <= 1'b0;
          r_stretching <= 1'b0;
          r_idle       <= 1'b1;
        end
      endcase
    end
  end

  assign scl_oe      = r_scl_oe;
  assign low_mid     = r_low_mid;
  assign high_mid    = r_high_mid;
  assign period_done = r_period_done;
  assign stretching  = r_stretching;
  assign idle        = r_idle;

endmodule : i2c_scl_timing_gen
`default_nettype wire

// File: tb/tb_i2c_scl_timing_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_i2c_scl_timing_gen
// Purpose  : Self-checking bench for i2c_scl_timing_gen. A monitor turns
//            each completed SCL period into a record of strobe offsets;
//            scenario tasks push model records and compare in order.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_scl_timing_gen;

  localparam int c_cnt_w   = 12;
  localparam int c_div_min = 4;
  localparam int c_budget  = 3000;

  logic               ref_clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               enable  = 1'b0;
  logic [1:0]         mode    = 2'b00;
  logic [c_cnt_w-1:0] custom_div = '0;
  logic               hold    = 1'b0;   // slave holding SCL low
  logic               scl_in;
  logic               scl_oe, low_mid, high_mid, period_done, stretching, idle;

  // Open-drain bus: low if master or slave pulls it
  assign scl_in = ~scl_oe & ~hold;

  i2c_scl_timing_gen dut (
    .ref_clk     (ref_clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .mode        (mode),
    .custom_div  (custom_div),
    .scl_in      (scl_in),
    .scl_oe      (scl_oe),
    .low_mid     (low_mid),
    .high_mid    (high_mid),
    .period_done (period_done),
    .stretching  (stretching),
    .idle        (idle)
  );

  always #10 ref_clk = ~ref_clk;

  // Offsets in cycles from the first SCL-low cycle of the period
  typedef struct packed {
    int lm;    // low_mid
    int fall;  // scl_oe release
    int hm;    // high_mid
    int pd;    // period_done
    int st;    // cycles with stretching=1
  } rec_t;

  rec_t exp_q[$];
  rec_t obs_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0, strobe_cnt = 0, pd_cnt = 0;
  int overlap_err = 0, width_err = 0, stray = 0;

  // Reference model: HIGH_A lasts div cycles unless the line, released by
  // the slave h cycles after the master released it, reaches scl_s (2 flops)
  // after the terminal count at div-1; then it lasts h+3 cycles.
  function automatic rec_t model(input int div, input int h);
    rec_t r;
    int d, ha;
    d  = (div < c_div_min) ? c_div_min : div;
    ha = (h + 3 > d) ? h + 3 : d;
    r.lm   = d;
    r.fall = 2 * d;
    r.hm   = 2 * d + ha;
    r.pd   = 3 * d + ha;
    r.st   = ha - d;
    return r;
  endfunction

  function automatic string fmt(input rec_t r);
    return $sformatf("lm=%0d fall=%0d hm=%0d pd=%0d st=%0d", r.lm, r.fall, r.hm, r.pd, r.st);
  endfunction

  // Monitor: sampled on the falling edge
  initial begin : monitor
    rec_t cur;
    int   start, ns;
    bit   in_per, p_oe, p_lm, p_hm, p_pd;
    cur = '0; start = 0; in_per = 0; p_oe = 0; p_lm = 0; p_hm = 0; p_pd = 0;
    forever begin
      @(negedge ref_clk);
      cyc++;
      if (!reset_n) begin
        in_per = 0; p_oe = 0; p_lm = 0; p_hm = 0; p_pd = 0;
      end else begin
        ns = int'(low_mid) + int'(high_mid) + int'(period_done);
        strobe_cnt += ns;
        if (ns > 1) overlap_err++;
        if ((low_mid && p_lm) || (high_mid && p_hm) || (period_done && p_pd)) width_err++;
        if (period_done) begin
          pd_cnt++;
          if (in_per) begin
            cur.pd = cyc - start;
            obs_q.push_back(cur);
            in_per = 0;
          end else begin
            stray++;
          end
        end
        if (in_per) begin
          if (low_mid)           cur.lm   = cyc - start;
          if (high_mid)          cur.hm   = cyc - start;
          if (p_oe && !scl_oe)   cur.fall = cyc - start;
          if (stretching)        cur.st   = cur.st + 1;
        end else if (low_mid || high_mid) begin
          stray++;
        end
        if (scl_oe && !p_oe) begin
          in_per = 1;
          start  = cyc;
          cur    = '{-1, -1, -1, -1, 0};
        end
        p_oe = scl_oe; p_lm = low_mid; p_hm = high_mid; p_pd = period_done;
      end
    end
  end

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic wait_obs(output rec_t r, output bit ok);
    ok = 0; r = '0;
    for (int i = 0; i < c_budget; i++) begin
      if (obs_q.size() > 0) begin
        r  = obs_q.pop_front();
        ok = 1;
        break;
      end
      @(negedge ref_clk);
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 0;
    for (int i = 0; i < c_budget; i++) begin
      @(negedge ref_clk);
      if (idle) begin ok = 1; break; end
    end
  endtask

  task automatic wait_low_mid(output bit ok);
    ok = 0;
    for (int i = 0; i < c_budget; i++) begin
      @(negedge ref_clk);
      if (low_mid) begin ok = 1; break; end
    end
  endtask

  // Run exactly one period from IDLE; slave keeps SCL low for h cycles
  // after the master releases it.
  task automatic start_one(input int h, output bit ok);
    hold   = (h > 0);
    enable = 1'b1;
    ok     = 0;
    for (int i = 0; i < c_budget; i++) begin
      @(negedge ref_clk);
      if (scl_oe) begin ok = 1; break; end
    end
    enable = 1'b0;
    if (ok) begin
      ok = 0;
      for (int i = 0; i < c_budget; i++) begin
        @(negedge ref_clk);
        if (!scl_oe) begin ok = 1; break; end
      end
    end
    repeat (h) @(negedge ref_clk);
    hold = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge ref_clk);
    n_checks++;
    if (scl_oe !== 1'b0) begin n_fail++; $display("FAIL reset_scl_oe: got %b want 0", scl_oe); end
    n_checks++;
    if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b want 1", idle); end
    n_checks++;
    if ({low_mid, high_mid, period_done} !== 3'b000) begin
      n_fail++; $display("FAIL reset_strobes: got %b want 000", {low_mid, high_mid, period_done});
    end
    n_checks++;
    if (stretching !== 1'b0) begin n_fail++; $display("FAIL reset_stretching: got %b want 0", stretching); end
    reset_n = 1'b1;
  endtask

  task automatic test_std_back_to_back;
    rec_t got, want;
    bit   ok;
    mode = 2'b00; hold = 1'b0; enable = 1'b1;
    exp_q.push_back(model(125, 0));
    exp_q.push_back(model(125, 0));
    for (int p = 0; p < 2; p++) begin
      wait_obs(got, ok);
      want = exp_q.pop_front();
      n_checks++;
      if (!ok || got !== want) begin
        n_fail++; $display("FAIL std_period%0d: got %s (seen=%0b) want %s", p, fmt(got), ok, fmt(want));
      end
    end
  endtask

  task automatic test_enable_drop;
    rec_t got, want;
    bit   ok, ok2;
    int   bad, s0;
    exp_q.push_back(model(125, 0));
    wait_low_mid(ok);                // now in LOW_B of the running period
    enable = 1'b0;
    wait_obs(got, ok2);
    want = exp_q.pop_front();
    n_checks++;
    if (!ok || !ok2 || got !== want) begin
      n_fail++; $display("FAIL drop_period: got %s (seen=%0b) want %s", fmt(got), ok && ok2, fmt(want));
    end
    n_checks++;
    if (idle !== 1'b1 || scl_oe !== 1'b0) begin
      n_fail++; $display("FAIL drop_idle: got idle=%b scl_oe=%b want idle=1 scl_oe=0", idle, scl_oe);
    end
    s0 = strobe_cnt; bad = 0;
    repeat (100) begin
      @(negedge ref_clk);
      if (scl_oe !== 1'b0 || idle !== 1'b1) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL drop_stays_idle: got %0d bad cycles want 0", bad); end
    n_checks++;
    if (strobe_cnt != s0) begin
      n_fail++; $display("FAIL drop_no_strobes: got %0d strobes want 0", strobe_cnt - s0);
    end
  endtask

  task automatic test_mode_switch;
    rec_t got, want;
    bit   ok, ok2;
    mode = 2'b01; hold = 1'b0; enable = 1'b1;
    exp_q.push_back(model(31, 0));
    exp_q.push_back(model(12, 0));
    wait_low_mid(ok);
    mode = 2'b10;                    // mid-period: must only affect the next one
    wait_obs(got, ok2);
    enable = 1'b0;
    want = exp_q.pop_front();
    n_checks++;
    if (!ok || !ok2 || got !== want) begin
      n_fail++; $display("FAIL mode_cur_period: got %s (seen=%0b) want %s", fmt(got), ok && ok2, fmt(want));
    end
    wait_obs(got, ok);
    want = exp_q.pop_front();
    n_checks++;
    if (!ok || got !== want) begin
      n_fail++; $display("FAIL mode_next_period: got %s (seen=%0b) want %s", fmt(got), ok, fmt(want));
    end
    wait_idle(ok);
  endtask

  task automatic test_custom_clamp;
    rec_t got, want;
    bit   ok, ok2, ok3;
    int   divs[3] = '{2, 0, 5};
    mode = 2'b11;
    foreach (divs[k]) begin
      custom_div = c_cnt_w'(divs[k]);
      exp_q.push_back(model(divs[k], 0));
      start_one(0, ok);
      custom_div = c_cnt_w'(9);      // mid-period change, ignored
      wait_obs(got, ok2);
      want = exp_q.pop_front();
      n_checks++;
      if (!ok || !ok2 || got !== want) begin
        n_fail++; $display("FAIL custom_div%0d: got %s (seen=%0b) want %s", divs[k], fmt(got), ok && ok2, fmt(want));
      end
      wait_idle(ok3);
    end
  endtask

  task automatic test_stretch;
    rec_t got, want;
    bit   ok, ok2, ok3;
    int   md[4] = '{0, 0, 3, 3};
    int   dv[4] = '{125, 125, 4, 4};
    int   hh[4] = '{40, 200, 2, 1};
    for (int k = 0; k < 4; k++) begin
      mode       = 2'(md[k]);
      custom_div = c_cnt_w'(dv[k]);
      exp_q.push_back(model(dv[k], hh[k]));
      start_one(hh[k], ok);
      wait_obs(got, ok2);
      want = exp_q.pop_front();
      n_checks++;
      if (!ok || !ok2 || got !== want) begin
        n_fail++; $display("FAIL stretch_div%0d_hold%0d: got %s (seen=%0b) want %s", dv[k], hh[k], fmt(got), ok && ok2, fmt(want));
      end
      wait_idle(ok3);
    end
  endtask

  task automatic test_reset_mid_period;
    rec_t got, want;
    bit   ok, ok2;
    int   pd0;
    mode = 2'b00; hold = 1'b0; enable = 1'b1;
    ok = 0;
    for (int i = 0; i < c_budget; i++) begin
      @(negedge ref_clk);
      if (scl_oe) begin ok = 1; break; end
    end
    repeat (50) @(negedge ref_clk);  // inside LOW_A
    pd0 = pd_cnt;
    reset_n = 1'b0;
    @(negedge ref_clk);
    n_checks++;
    if (!ok || scl_oe !== 1'b0 || idle !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_release: got scl_oe=%b idle=%b want scl_oe=0 idle=1", scl_oe, idle);
    end
    n_checks++;
    if ({low_mid, high_mid, period_done} !== 3'b000) begin
      n_fail++; $display("FAIL rst_mid_strobes: got %b want 000", {low_mid, high_mid, period_done});
    end
    @(negedge ref_clk);
    reset_n = 1'b1;
    exp_q.push_back(model(125, 0));
    ok = 0;
    for (int i = 0; i < c_budget; i++) begin
      @(negedge ref_clk);
      if (scl_oe) begin ok = 1; break; end
    end
    enable = 1'b0;
    wait_obs(got, ok2);
    want = exp_q.pop_front();
    n_checks++;
    if (!ok || !ok2 || got !== want) begin
      n_fail++; $display("FAIL rst_restart_period: got %s (seen=%0b) want %s", fmt(got), ok && ok2, fmt(want));
    end
    n_checks++;
    if (pd_cnt != pd0 + 1) begin
      n_fail++; $display("FAIL rst_period_done_count: got %0d want 1", pd_cnt - pd0);
    end
    wait_idle(ok);
  endtask

  task automatic test_strobe_rules;
    n_checks++;
    if (overlap_err != 0) begin n_fail++; $display("FAIL strobe_overlap: got %0d want 0", overlap_err); end
    n_checks++;
    if (width_err != 0) begin n_fail++; $display("FAIL strobe_width: got %0d want 0", width_err); end
    n_checks++;
    if (stray != 0) begin n_fail++; $display("FAIL strobe_stray: got %0d want 0", stray); end
  endtask

  initial begin
    test_reset();
    test_std_back_to_back();
    test_enable_drop();
    test_mode_switch();
    test_custom_clamp();
    test_stretch();
    test_reset_mid_period();
    test_strobe_rules();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_i2c_scl_timing_gen
`default_nettype wire
